// File: rtl/timer_dev.sv
// timer_dev: bus-mapped countdown timer with one-shot latched irq or auto-reload pulse irq.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;
  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
  logic             pend_q, pend_d, en_d, auto_q, wr_ctrl, wr_pre;
  assign auto_q  = ctrl_q[2:1] == 2'b01;
  assign wr_ctrl = we && be == 4'hf && addr == 2'd0;
  assign wr_pre  = we && be == 4'hf && addr == 2'd1;
  assign irq     = pend_q & ctrl_q[3];
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    en_d    = ctrl_q[0];
    pend_d  = auto_q ? 1'b0 : pend_q;
    case (state_q)
      S_IDLE: state_d = ctrl_q[0] ? S_LOAD : S_IDLE;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        state_d = !ctrl_q[0] ? S_IDLE : count_q <= CNT_W'(1) ? S_INT : S_CNT;
        count_d = !ctrl_q[0] ? count_q : count_q <= CNT_W'(1) ? '0 : count_q - CNT_W'(1);
      end
      default: begin
        pend_d  = 1'b1;
        en_d    = auto_q;
        state_d = S_IDLE;
      end
    endcase
    // bus writes override whatever the FSM decided this edge
    ctrl_d   = wr_ctrl ? wd[3:0] : {ctrl_q[3:1], en_d};
    preset_d = wr_pre ? wd[CNT_W-1:0] : preset_q;
    pend_d   = (wr_ctrl || wr_pre) ? 1'b0 : pend_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end
  always_comb
    rd = addr == 2'd0 ? 32'(ctrl_q) :
         addr == 2'd1 ? 32'(preset_q) :
         addr == 2'd2 ? 32'(count_q) : 32'h0;
endmodule
